// File: rtl/cache.sv
// Direct-mapped, write-through, no-write-allocate cache with 4-word lines.
// Reads hit in zero cycles; misses refill the whole line, and writes always go to memory.
module cache #(
    parameter int INDEX_BITS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           beat_q, beat_d;
    logic [LINES-1:0]     valid_q, valid_d;

    logic [TAG_BITS-1:0]  tag_mem  [LINES];
    logic [31:0]          data_mem [LINES*4];

    logic [TAG_BITS-1:0]  addr_tag;
    logic [INDEX_BITS-1:0] addr_index;
    logic [1:0]           addr_word;
    logic                 hit;

    logic                 data_we;
    logic [INDEX_BITS+1:0] data_waddr;
    logic [31:0]          data_wval;
    logic                 tag_we;
    logic                 unused_addr_bits;

    assign addr_tag         = cpu_addr[31:4+INDEX_BITS];
    assign addr_index       = cpu_addr[3+INDEX_BITS:4];
    assign addr_word        = cpu_addr[3:2];
    assign hit              = valid_q[addr_index] && (tag_mem[addr_index] == addr_tag);
    assign unused_addr_bits = ^cpu_addr[1:0];

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        valid_d    = valid_q;
        cpu_ready  = 1'b0;
        cpu_rdata  = 32'h0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        data_we    = 1'b0;
        data_waddr = {addr_index, addr_word};
        data_wval  = cpu_wdata;
        tag_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        state_d = WRITE;
                    end else if (hit) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = data_mem[{addr_index, addr_word}];
                    end else begin
                        // Drop the victim now so an aborted refill never leaves stale words marked valid.
                        state_d             = REFILL;
                        beat_d              = 2'd0;
                        valid_d[addr_index] = 1'b0;
                    end
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {cpu_addr[31:4], beat_q, 2'b00};
                if (mem_ready) begin
                    data_we    = 1'b1;
                    data_waddr = {addr_index, beat_q};
                    data_wval  = mem_rdata;
                    beat_d     = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        valid_d[addr_index] = 1'b1;
                        tag_we              = 1'b1;
                        state_d             = IDLE;
                    end
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {cpu_addr[31:2], 2'b00};
                mem_wdata = cpu_wdata;
                if (mem_ready) begin
                    cpu_ready = 1'b1;
                    data_we   = hit;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
        end
    end

    // Data and tag storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[data_waddr] <= data_wval;
        if (tag_we) tag_mem[addr_index] <= addr_tag;
    end

endmodule

// File: tb/tb_cache.sv
// Bench for the cache: a randomised-latency memory responder plus a
// reference cache/memory model feeding expected queues.
module tb_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_beat_cyc = 0;
  int beat_cnt = 0;
  int wait_cnt = 0;
  bit stray = 1'b0;

  logic [64:0] exp_mem_q[$];
  logic [31:0] exp_rd_q[$];
  logic [64:0] resp_e;
  logic [31:0] gold [logic [31:0]];
  logic [31:0] mem_store [logic [31:0]];
  bit          valid_m [32];
  logic [22:0] tag_m [32];

  cache #(.INDEX_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] def_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] gold_val(input logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return def_val(a);
  endfunction

  // Memory responder: answers each requested word after 0-2 wait cycles.
  always @(negedge clk) begin
    cyc++;
    mem_ready = 1'b0;
    if (rst) begin
      wait_cnt = 0;
    end else if (mem_req) begin
      if (wait_cnt > 0) begin
        wait_cnt--;
      end else begin
        mem_ready = 1'b1;
        beat_cnt++;
        last_beat_cyc = cyc;
        wait_cnt = $urandom_range(0, 2);
        checks++;
        if (exp_mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: got we=%0b addr=%h wdata=%h, required no transfer", mem_we, mem_addr, mem_wdata);
        end else begin
          resp_e = exp_mem_q.pop_front();
          if ({mem_we, mem_addr, mem_wdata} !== resp_e) begin
            errors++;
            $display("FAIL mem_xfer: got {we,addr,wdata}=%h, required %h", {mem_we, mem_addr, mem_wdata}, resp_e);
          end
        end
        if (mem_we) mem_store[mem_addr] = mem_wdata;
        else mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : def_val(mem_addr);
      end
    end else if (stray) begin
      mem_ready = 1'b1;
      mem_rdata = $urandom;
    end
  end

  task automatic cpu_read(input logic [31:0] addr);
    int idx;
    bit hit;
    int cycles;
    bit done;
    logic [31:0] a;
    logic [31:0] exp;
    a = {addr[31:2], 2'b00};
    idx = addr[8:4];
    hit = valid_m[idx] && (tag_m[idx] == addr[31:9]);
    if (!hit) begin
      for (int i = 0; i < 4; i++) begin
        logic [1:0] b;
        b = i[1:0];
        exp_mem_q.push_back({1'b0, addr[31:4], b, 2'b00, 32'h0});
      end
      valid_m[idx] = 1'b1;
      tag_m[idx] = addr[31:9];
    end
    exp_rd_q.push_back(gold_val(a));
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr; cpu_wdata = $urandom;
    cycles = 0; done = 1'b0;
    while (!done && cycles < 60) begin
      @(negedge clk); #2;
      cycles++;
      if (cpu_ready) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL read_timeout: addr %h got no cpu_ready in %0d cycles, required completion", addr, cycles);
      exp_rd_q.delete();
      exp_mem_q.delete();
    end else begin
      exp = exp_rd_q.pop_front();
      if (cpu_rdata !== exp) begin
        errors++;
        $display("FAIL read_data: addr %h got %h, required %h", addr, cpu_rdata, exp);
      end
      checks++;
      if (hit && (cycles !== 1 || mem_req !== 1'b0)) begin
        errors++;
        $display("FAIL hit_latency: addr %h got %0d cycles mem_req=%0b, required 1 cycle mem_req=0", addr, cycles, mem_req);
      end else if (!hit && cyc !== last_beat_cyc + 1) begin
        errors++;
        $display("FAIL miss_latency: addr %h ready at cycle %0d, required %0d", addr, cyc, last_beat_cyc + 1);
      end
      checks++;
      if (exp_mem_q.size() != 0) begin
        errors++;
        $display("FAIL refill_beats: addr %h got %0d beats outstanding, required 0", addr, exp_mem_q.size());
        exp_mem_q.delete();
      end
    end
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
    int cycles;
    bit done;
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    exp_mem_q.push_back({1'b1, a, data});
    gold[a] = data;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = data;
    cycles = 0; done = 1'b0;
    while (!done && cycles < 60) begin
      @(negedge clk); #2;
      cycles++;
      if (cpu_ready) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL write_timeout: addr %h got no cpu_ready in %0d cycles, required completion", addr, cycles);
      exp_mem_q.delete();
    end else begin
      if (cyc !== last_beat_cyc || exp_mem_q.size() != 0 || cpu_rdata !== 32'h0) begin
        errors++;
        $display("FAIL write_done: addr %h ready cyc %0d beat cyc %0d outstanding %0d rdata %h, required same cycle, 0 outstanding, rdata 0",
                 addr, cyc, last_beat_cyc, exp_mem_q.size(), cpu_rdata);
        exp_mem_q.delete();
      end
    end
  endtask

  task automatic cpu_idle();
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) valid_m[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    checks++;
    if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_cpu: got ready=%0b rdata=%h, required 0/0", cpu_ready, cpu_rdata);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: got req=%0b we=%0b addr=%h wdata=%h, required all 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_refill();
    gold[32'h40] = 32'h11; gold[32'h44] = 32'h22; gold[32'h48] = 32'h33; gold[32'h4C] = 32'h44;
    mem_store[32'h40] = 32'h11; mem_store[32'h44] = 32'h22;
    mem_store[32'h48] = 32'h33; mem_store[32'h4C] = 32'h44;
    cpu_read(32'h40);
  endtask

  task automatic test_read_hit();
    cpu_read(32'h48);
    cpu_read(32'h4C);
    cpu_read(32'h41);
  endtask

  task automatic test_idle();
    cpu_idle();
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk); #2;
      checks++;
      if ({cpu_ready, mem_req, mem_we} !== 3'b000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || cpu_rdata !== 32'h0) begin
        errors++;
        $display("FAIL idle_outputs: got ready=%0b req=%0b we=%0b addr=%h wdata=%h rdata=%h, required all 0",
                 cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, cpu_rdata);
      end
    end
    stray = 1'b0;
    cpu_read(32'h44);
  endtask

  task automatic test_write_hit();
    cpu_write(32'h44, 32'hDEADBEEF);
    cpu_read(32'h44);
    cpu_read(32'h40);
  endtask

  task automatic test_write_miss();
    cpu_write(32'h1000, 32'h12345678);
    cpu_read(32'h1000);
  endtask

  task automatic test_conflict();
    cpu_read(32'h240);
    cpu_read(32'h40);
  endtask

  task automatic test_reset_mid_refill();
    int base;
    int n;
    base = beat_cnt;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] b;
      b = i[1:0];
      exp_mem_q.push_back({1'b0, 28'h030, b, 2'b00, 32'h0});
    end
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
    n = 0;
    while (beat_cnt < base + 2 && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    checks++;
    if (beat_cnt != base + 2) begin
      errors++;
      $display("FAIL abort_beats: got %0d beats, required 2", beat_cnt - base);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: got mem_req=%0b cpu_ready=%0b, required 0/0", mem_req, cpu_ready);
    end
    exp_mem_q.delete();
    clear_model();
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cpu_read(32'h300);
    cpu_read(32'h48);
  endtask

  task automatic test_drop_req();
    int base;
    int n;
    base = beat_cnt;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] b;
      b = i[1:0];
      exp_mem_q.push_back({1'b0, 28'h050, b, 2'b00, 32'h0});
    end
    valid_m[16] = 1'b1;
    tag_m[16] = 23'd2;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h500;
    n = 0;
    while (beat_cnt < base + 1 && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n = 0;
    while (exp_mem_q.size() != 0 && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    checks++;
    if (exp_mem_q.size() != 0) begin
      errors++;
      $display("FAIL drop_refill: got %0d beats outstanding, required 0", exp_mem_q.size());
      exp_mem_q.delete();
    end
    repeat (2) @(posedge clk);
    cpu_read(32'h504);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      logic [31:0] addr;
      addr = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) cpu_write(addr, $urandom);
      else cpu_read(addr);
    end
    cpu_idle();
  endtask

  initial begin
    test_reset();
    test_refill();
    test_read_hit();
    test_idle();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_reset_mid_refill();
    test_drop_req();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache.md
CACHE -- requirements
Module: cache

Interface
REQ-001 INDEX_BITS, default 5, line-index width; the cache SHALL have 2^INDEX_BITS lines (32 by default).
REQ-002 Line size SHALL be fixed at 4 words of 32 bits (16 bytes); word offset = addr[3:2].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cpu_req  input  1  CPU access request.
REQ-006 cpu_we  input  1  1 = write, 0 = read.
REQ-007 cpu_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 cpu_wdata  input  32  write data.
REQ-009 cpu_rdata  output  32  read data, valid while cpu_ready=1 on a read.
REQ-010 cpu_ready  output  1  access complete this cycle; CPU stalls while cpu_req=1 and cpu_ready=0.
REQ-011 mem_req  output  1  memory request.
REQ-012 mem_we  output  1  1 = memory write.
REQ-013 mem_addr  output  32  word-aligned memory address (bits [1:0] = 0).
REQ-014 mem_wdata  output  32  memory write data.
REQ-015 mem_rdata  input  32  memory read data, valid when mem_ready=1.
REQ-016 mem_ready  input  1  memory completes one word transfer this cycle.

Function
REQ-017 Organisation SHALL be direct-mapped, write-through, no-write-allocate; address split: tag = addr[31:4+INDEX_BITS], index = addr[3+INDEX_BITS:4], word = addr[3:2].
REQ-018 Each line SHALL hold a valid bit, a tag and 4 data words; hit = valid[index] and tag match.
REQ-019 FSM states SHALL be IDLE, REFILL, WRITE.
REQ-020 IDLE, cpu_req=0: cpu_ready=0, mem_req=0, no state change.
REQ-021 IDLE, read hit: cpu_ready=1 and cpu_rdata=line word combinationally in the same cycle (0-cycle latency); stay IDLE.
REQ-022 IDLE, read miss: cpu_ready=0; next state REFILL; beat counter cleared to 0.
REQ-023 REFILL: mem_req=1, mem_we=0, mem_addr={tag,index,beat,2'b00}; on each mem_ready=1 the SHALL write mem_rdata into word[beat] and increment beat; on beat 3 with mem_ready=1 the SHALL set valid and store tag, then go to IDLE.
REQ-024 After a refill the re-presented read SHALL hit in the first IDLE cycle; total read-miss latency = 4 mem_ready beats + 1 cycle.
REQ-025 IDLE, write (hit or miss): cpu_ready=0; next state WRITE.
REQ-026 WRITE: mem_req=1, mem_we=1, mem_addr={cpu_addr[31:2],2'b00}, mem_wdata=cpu_wdata; the cycle mem_ready=1: cpu_ready=1, on a hit the cached word SHALL be updated, and the next state SHALL be IDLE; a write miss SHALL NOT change any line.
REQ-027 The CPU SHALL hold cpu_req/cpu_we/cpu_addr/cpu_wdata stable until cpu_ready=1; the cache SHALL NOT latch them.
REQ-028 cpu_req dropped mid-REFILL: the refill SHALL complete and validate the line; dropped mid-WRITE: the memory write SHALL complete.
REQ-029 mem_ready in IDLE SHALL be ignored; mem_req, mem_we and cpu_ready SHALL be 0 in IDLE except as in REQ-021.
REQ-030 A miss to an index holding another tag SHALL overwrite that line (no write-back needed).
REQ-031 Outputs not specified for a state SHALL drive 0.

Reset
REQ-032 rst=1 SHALL immediately clear all valid bits, beat counter and FSM to IDLE; cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, cpu_rdata SHALL read 0.
REQ-033 Reset during REFILL or WRITE SHALL abort the transfer; the partially filled line SHALL remain invalid.
REQ-034 Data array contents need not be cleared by reset.

Verification
REQ-035 After reset, read 0x0000_0040 with memory returning 0x11,0x22,0x33,0x44 on 4 beats -> mem_addr 0x40,0x44,0x48,0x4C, then cpu_ready=1, cpu_rdata=0x11.
REQ-036 Then read 0x0000_0048 -> hit, cpu_ready=1 same cycle, cpu_rdata=0x33, mem_req=0.
REQ-037 Write 0xDEADBEEF to 0x0000_0044 (hit) -> mem_we=1, mem_addr=0x44, after mem_ready cpu_ready=1; subsequent read 0x44 hits with 0xDEADBEEF.
REQ-038 Write 0x12345678 to 0x0000_1000 (miss) -> memory write only; subsequent read 0x1000 misses and refills.
REQ-039 Read 0x0000_0240 (same index as 0x40, different tag) -> miss, refill replaces line; read 0x40 then misses.
REQ-040 Assert rst after 2 refill beats -> mem_req=0 at once, FSM IDLE; re-read same address misses and performs full 4-beat refill.
